nn_udiv_31ns_6ns_seq: RTL and testbench



---
 rtl/nn_udiv_pkg.sv | 17 +
 rtl/nn_udiv_step.sv | 17 +
 rtl/nn_udiv_31ns_6ns_seq.sv | 138 +++++++++++++
 tb/tb_nn_udiv_31ns_6ns_seq.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/nn_udiv_pkg.sv
// Shared types and defaults for the NN sequential unsigned divider.
package nn_udiv_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  localparam int DEF_DIVIDEND_WIDTH = 31;
  localparam int DEF_DIVISOR_WIDTH  = 6;
  localparam int DEF_QUOT_WIDTH     = 25;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/nn_udiv_step.sv
// One radix-2 restoring step: shift in a dividend bit, trial-subtract, restore on borrow.
module nn_udiv_step #(
  parameter int DIVISOR_WIDTH = 6
) (
  input  logic [DIVISOR_WIDTH:0]   rem_i,
  input  logic                     bit_i,
  input  logic [DIVISOR_WIDTH-1:0] dvs_i,
  output logic [DIVISOR_WIDTH:0]   rem_o,
  output logic                     q_o
);

  localparam int RW = DIVISOR_WIDTH + 1;

  assign q_o   = ({rem_i, bit_i} >= {2'b00, dvs_i});
  assign rem_o = q_o ? RW'({rem_i, bit_i} - {2'b00, dvs_i}) : RW'({rem_i, bit_i});

endmodule

// File: rtl/nn_udiv_31ns_6ns_seq.sv
// Sequential restoring divider, one quotient bit per cycle, valid/ready on both sides.
// Define NN_UDIV_EARLY_EXIT_EN to short-circuit dividend < divisor at accept.
module nn_udiv_31ns_6ns_seq
  import nn_udiv_pkg::*;
#(
  parameter int DIVIDEND_WIDTH = DEF_DIVIDEND_WIDTH,
  parameter int DIVISOR_WIDTH  = DEF_DIVISOR_WIDTH,
  parameter int QUOT_WIDTH     = DEF_QUOT_WIDTH
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DIVIDEND_WIDTH-1:0] din0,
  input  logic [DIVISOR_WIDTH-1:0]  din1,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [QUOT_WIDTH-1:0]     quot,
  output logic [DIVISOR_WIDTH-1:0]  rem,
  output logic                      dbz,
  output logic                      ovf
);

  localparam int RW = DIVISOR_WIDTH + 1;
  localparam int CW = clog2(DIVIDEND_WIDTH);

  state_e                    state_q, state_d;
  logic [DIVIDEND_WIDTH-1:0] dvd_q, dvd_d;
  logic [DIVISOR_WIDTH-1:0]  dvs_q, dvs_d;
  logic [RW-1:0]             prem_q, prem_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [QUOT_WIDTH-1:0]     quot_q, quot_d;
  logic [DIVISOR_WIDTH-1:0]  rem_q, rem_d;
  logic                      dbz_q, dbz_d;
  logic                      ovf_q, ovf_d;

  logic [RW-1:0]             step_rem;
  logic                      step_q;
  logic [DIVIDEND_WIDTH-1:0] quot_full;

  nn_udiv_step #(.DIVISOR_WIDTH(DIVISOR_WIDTH)) u_step (
    .rem_i (prem_q),
    .bit_i (dvd_q[DIVIDEND_WIDTH-1]),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  // The dividend shifts out of the top while quotient bits fill from the bottom.
  assign quot_full = {dvd_q[DIVIDEND_WIDTH-2:0], step_q};

  assign in_ready  = (state_q == IDLE) && !ap_rst;
  assign out_valid = (state_q == DONE);
  assign quot      = quot_q;
  assign rem       = rem_q;
  assign dbz       = dbz_q;
  assign ovf       = ovf_q;

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    prem_d  = prem_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          dvd_d   = din0;
          dvs_d   = din1;
          prem_d  = '0;
          cnt_d   = CW'(DIVIDEND_WIDTH - 1);
          state_d = BUSY;
          if (din1 == '0) begin
            state_d = DONE;
            quot_d  = '1;
            rem_d   = '0;
            dbz_d   = 1'b1;
            ovf_d   = 1'b0;
          end
`ifdef NN_UDIV_EARLY_EXIT_EN
          else if (din0 < DIVIDEND_WIDTH'(din1)) begin
            state_d = DONE;
            quot_d  = '0;
            rem_d   = din0[DIVISOR_WIDTH-1:0];
            dbz_d   = 1'b0;
            ovf_d   = 1'b0;
          end
`endif
        end
      end
      BUSY: begin
        prem_d = step_rem;
        dvd_d  = quot_full;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = DONE;
          quot_d  = quot_full[QUOT_WIDTH-1:0];
          rem_d   = step_rem[DIVISOR_WIDTH-1:0];
          dbz_d   = 1'b0;
          ovf_d   = (quot_full >> QUOT_WIDTH) != '0;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      prem_q  <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      prem_q  <= prem_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_nn_udiv_31ns_6ns_seq.sv
// Bench for nn_udiv_31ns_6ns_seq: directed cases plus random operands against an arithmetic model.
module tb_nn_udiv_31ns_6ns_seq;

  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [30:0] din0 = '0;
  logic [5:0]  din1 = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [24:0] quot;
  logic [5:0]  rem;
  logic        dbz;
  logic        ovf;

  int n_cmp = 0;
  int n_err = 0;

  always #5 ap_clk = ~ap_clk;

  nn_udiv_31ns_6ns_seq dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din0      (din0),
    .din1      (din1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quot      (quot),
    .rem       (rem),
    .dbz       (dbz),
    .ovf       (ovf)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    @(negedge ap_clk);
  endtask

  // Arithmetic reference: results and edges-after-accept until out_valid.
  task automatic model(input logic [30:0] a, input logic [5:0] b,
                       output longint eq, output longint er, output logic ed,
                       output logic eo, output int elat);
    longint full;
    if (b == 0) begin
      eq = (64'd1 << 25) - 1; er = 0; ed = 1'b1; eo = 1'b0; elat = 0;
    end else begin
      full = longint'(a) / longint'(b);
      eq   = full % (64'd1 << 25);
      er   = longint'(a) % longint'(b);
      ed   = 1'b0;
      eo   = (full >= (64'd1 << 25));
      elat = 31;
`ifdef NN_UDIV_EARLY_EXIT_EN
      if (longint'(a) < longint'(b)) elat = 0;
`endif
    end
  endtask

  task automatic run_op(input logic [30:0] a, input logic [5:0] b, input int hold, input string tag);
    longint eq, er;
    logic   ed, eo;
    int     elat, lat, w;
    model(a, b, eq, er, ed, eo, elat);
    @(negedge ap_clk);
    w = 0;
    while (!in_ready && w < 100) begin tick(); w++; end
    if (!in_ready) chk({tag, ".accept_wait"}, in_ready, 1);
    in_valid  = 1'b1;
    din0      = a;
    din1      = b;
    out_ready = (hold == 0);
    tick();
    in_valid = 1'b0;
    din0     = $urandom;
    din1     = 6'($urandom);
    chk({tag, ".in_ready_busy"}, in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 200) begin tick(); lat++; end
    chk({tag, ".latency"}, lat, elat);
    chk({tag, ".out_valid"}, out_valid, 1);
    chk({tag, ".quot"}, quot, eq);
    chk({tag, ".rem"}, rem, er);
    chk({tag, ".dbz"}, dbz, ed);
    chk({tag, ".ovf"}, ovf, eo);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, ".hold_valid"}, out_valid, 1);
      chk({tag, ".hold_quot"}, quot, eq);
      chk({tag, ".hold_rem"}, rem, er);
      chk({tag, ".hold_in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    chk({tag, ".valid_drop"}, out_valid, 0);
    chk({tag, ".in_ready_after"}, in_ready, 1);
    chk({tag, ".quot_kept"}, quot, eq);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [30:0] a;
    logic [5:0]  b;
    @(negedge ap_clk);
    tick();
    chk("rst.in_ready", in_ready, 0);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.quot", quot, 0);
    chk("rst.rem", rem, 0);
    chk("rst.dbz", dbz, 0);
    chk("rst.ovf", ovf, 0);
    ap_rst = 1'b0;
    tick();
    chk("rst.in_ready_rel", in_ready, 1);

    run_op(31'd1000, 6'd7, 0, "d1000_7");
    run_op(31'd2147483647, 6'd1, 0, "dmax_1");
    run_op(31'd12345, 6'd0, 0, "dbz");
    run_op(31'd600, 6'd50, 5, "d600_50_hold");
    run_op(31'd5, 6'd9, 0, "d5_9");
    run_op(31'd0, 6'd63, 0, "d0_63");
    run_op(31'h7fffffff, 6'd63, 1, "dmax_63");

    // Abort mid-operation: reset must swallow the result.
    @(negedge ap_clk);
    in_valid = 1'b1; din0 = 31'd999; din1 = 6'd3;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    ap_rst = 1'b1;
    tick();
    chk("abort.in_ready_rst", in_ready, 0);
    chk("abort.out_valid_rst", out_valid, 0);
    ap_rst = 1'b0;
    tick();
    chk("abort.in_ready", in_ready, 1);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
        if (out_valid) seen++;
        tick();
      end
      chk("abort.no_valid", seen, 0);
    end
    run_op(31'd9, 6'd3, 0, "d9_3");

    for (int k = 0; k < 200; k++) begin
      a = (($urandom_range(0, 3) == 0) ? 31'($urandom_range(0, 80)) : 31'($urandom));
      b = (($urandom_range(0, 15) == 0) ? 6'd0 : 6'($urandom_range(1, 63)));
      run_op(a, b, $urandom_range(0, 2), $sformatf("rnd%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
